// File: rtl/wb_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used by both the bus master and the core.
package wb_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } lsu_state_t;

  // Size code 2'b11 behaves as a word access, so any size with bit 1 set is a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    is_misaligned = ((size == SZ_HALF) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for stores and lane extraction plus
// sign/zero extension for loads; shared with the core's fetch path.
module lsu_lane_align
  import wb_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic zext);
    logic signed [7:0]  sb;
    logic signed [31:0] sw;
    sb = b;
    sw = sb;
    ext_byte = zext ? {24'h000000, b} : sw;
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic zext);
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sh = h;
    sw = sh;
    ext_half = zext ? {16'h0000, h} : sw;
  endfunction

  logic [31:0] rdata_shift;

  always_comb begin
    sel         = 4'b1111;
    wdata_lane  = wdata;
    rdata_shift = rdata >> {offset, 3'b000};
    rdata_ext   = rdata_shift;
    case (size)
      SZ_BYTE: begin
        sel        = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = ext_byte(rdata_shift[7:0], is_unsigned);
      end
      SZ_HALF: begin
        sel        = 4'b0011 << offset;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = ext_half(rdata_shift[15:0], is_unsigned);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone classic-pipelined master executing one CPU load/store per
// transaction, with misalignment detection and a bus timeout.
module wb_lsu_master
  import wb_lsu_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [31:0]       o_wb_data,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [31:0]       i_wb_data
);

  localparam int CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  lsu_state_t        state, state_nxt;
  logic              we_q, uns_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [1:0]        size_q;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              cyc, accept_req, req_misal, ack_take, tmo_hit, tmo_abort;
  logic [3:0]        sel_lane;
  logic [31:0]       wdata_lane, rdata_ext;

  lsu_lane_align u_align (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (i_wb_data),
    .sel         (sel_lane),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cyc        = (state == ST_STROBE) || (state == ST_WAIT_ACK);
    accept_req = (state == ST_IDLE) && i_req;
    req_misal  = is_misaligned(i_size, i_addr[1:0]);
    tmo_hit    = (TIMEOUT != 0) && cyc && (tmo_cnt == CNT_W'(TMO_LAST));
    ack_take   = ((state == ST_STROBE) && !i_wb_stall && i_wb_ack) ||
                 ((state == ST_WAIT_ACK) && i_wb_ack);
    tmo_abort  = tmo_hit && !ack_take;
    case (state)
      ST_IDLE:     if (i_req) state_nxt = req_misal ? ST_DONE : ST_STROBE;
      // A timeout on the final strobe cycle wins over acceptance so cyc never overruns.
      ST_STROBE:   if (ack_take || tmo_abort) state_nxt = ST_DONE;
                   else if (!i_wb_stall)      state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack_take || tmo_abort) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      tmo_cnt <= '0;
    end else begin
      if (accept_req)     err_q   <= req_misal;
      else if (tmo_abort) err_q   <= 1'b1;
      if (ack_take)       rdata_q <= rdata_ext;
      tmo_cnt <= cyc ? tmo_cnt + 1'b1 : '0;
    end
  end

  // Request payload: only observable while cyc is high, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (accept_req) begin
      we_q    <= i_we;
      addr_q  <= i_addr;
      wdata_q <= i_wdata;
      size_q  <= i_size;
      uns_q   <= i_unsigned;
    end
  end

  assign o_busy    = cyc;
  assign o_done    = (state == ST_DONE);
  assign o_err     = (state == ST_DONE) && err_q;
  assign o_rdata   = rdata_q;
  assign o_wb_cyc  = cyc;
  assign o_wb_stb  = (state == ST_STROBE);
  assign o_wb_we   = cyc && we_q;
  assign o_wb_addr = cyc ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign o_wb_sel  = cyc ? sel_lane : 4'b0000;
  assign o_wb_data = (cyc && we_q) ? wdata_lane : 32'h0;

endmodule
